// File: rtl/mem_resp_pkg.sv
// Shared defaults for the memory responder and its read-return delay line.
package mem_resp_pkg;

  localparam int unsigned MR_ADDR_W = 8;
  localparam int unsigned MR_DATA_W = 8;
  localparam int unsigned MR_DEPTH  = 200;
  localparam int unsigned MR_RD_LAT = 2;

  // Returned for out-of-range reads; truncated to the data width at use.
  localparam int unsigned             MR_FILL_W   = 64;
  localparam logic [MR_FILL_W-1:0]    MR_OOR_FILL = '1;

endpackage

// File: rtl/mem_resp_pipe.sv
// Read-return delay line: RD_LAT registered stages carrying {valid, err, data}.
// Payload only advances with a valid beat, so the last stage holds the last returned word.
module mem_resp_pipe #(
  parameter int unsigned W      = 8,
  parameter int unsigned RD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic         i_err,
  input  logic [W-1:0] i_data,
  input  logic         i_side_err,
  output logic         o_valid,
  output logic         o_err,
  output logic [W-1:0] o_data
);

  logic [RD_LAT-1:0]        r_valid;
  logic [RD_LAT-1:0]        r_err;
  logic [RD_LAT-1:0][W-1:0] r_data;

  logic [RD_LAT:0]          w_valid;
  logic [RD_LAT:0]          w_err;
  logic [RD_LAT:0][W-1:0]   w_data;
  logic [RD_LAT-1:0]        w_err_nxt;

  assign w_valid = {r_valid, i_valid};
  assign w_err   = {r_err, i_err};
  assign w_data  = {r_data, i_data};

  // err is a pulse: only valid beats carry it; write errors land directly in the last stage.
  assign w_err_nxt = (w_valid[RD_LAT-1:0] & w_err[RD_LAT-1:0]) |
                     (RD_LAT'(i_side_err) << (RD_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_err   <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= w_valid[RD_LAT-1:0];
      r_err   <= w_err_nxt;
      for (int unsigned s = 0; s < RD_LAT; s++) begin
        if (w_valid[s]) r_data[s] <= w_data[s];
      end
    end
  end

  assign o_valid = r_valid[RD_LAT-1];
  assign o_err   = r_err[RD_LAT-1];
  assign o_data  = r_data[RD_LAT-1];

endmodule

// File: rtl/mem_responder.sv
// Single-port flop-array memory answering one request per cycle, reads returned after RD_LAT.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = MR_ADDR_W,
  parameter int unsigned DATA_W = MR_DATA_W,
  parameter int unsigned DEPTH  = MR_DEPTH,
  parameter int unsigned RD_LAT = MR_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              err
);

  localparam int unsigned       IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] FILL  = DATA_W'(MR_OOR_FILL);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_wr_en;
  logic              w_rd_req;
  logic              w_wr_oor;
  logic [DATA_W-1:0] w_rd_data;

  assign w_in_range = 32'(addr) < DEPTH;
  assign w_idx      = IDX_W'(addr);
  assign w_wr_en    = enable & ~read & w_in_range;
  assign w_rd_req   = enable & read;
  assign w_wr_oor   = enable & ~read & ~w_in_range;
  // Read sees the array after any write of the previous edge, so no bypass is needed.
  assign w_rd_data  = w_in_range ? r_mem[w_idx] : FILL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[w_idx] <= wdata;
    end
  end

  mem_resp_pipe #(
    .W      (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (w_rd_req),
    .i_err      (~w_in_range),
    .i_data     (w_rd_data),
    .i_side_err (w_wr_oor),
    .o_valid    (data_valid),
    .o_err      (err),
    .o_data     (data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: three responders (RD_LAT 1, 2, 4) share one stimulus stream;
// outputs are logged per cycle and compared against hand-computed responses.
module tb_mem_responder;

  localparam int NH = 1024;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       read;
  logic [7:0] addr;
  logic [7:0] wdata;

  logic [7:0] d1, d2, d4;
  logic       v1, v2, v4;
  logic       e1, e2, e4;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic       hv [3][NH];
  logic       he [3][NH];
  logic [7:0] hd [3][NH];

  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .read(read), .addr(addr),
    .wdata(wdata), .data(d1), .data_valid(v1), .err(e1));
  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .read(read), .addr(addr),
    .wdata(wdata), .data(d2), .data_valid(v2), .err(e2));
  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .RD_LAT(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .read(read), .addr(addr),
    .wdata(wdata), .data(d4), .data_valid(v4), .err(e4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Index n holds the outputs visible after the n-th rising edge.
  always @(negedge clk) begin
    if (cyc < NH) begin
      hv[0][cyc] = v1; he[0][cyc] = e1; hd[0][cyc] = d1;
      hv[1][cyc] = v2; he[1][cyc] = e2; hd[1][cyc] = d2;
      hv[2][cyc] = v4; he[2][cyc] = e4; hd[2][cyc] = d4;
    end
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_now(input string tag);
    chk({tag, " data L1"}, 32'(d1), 32'h0);
    chk({tag, " data L2"}, 32'(d2), 32'h0);
    chk({tag, " data L4"}, 32'(d4), 32'h0);
    chk({tag, " valid"}, 32'({v1, v2, v4}), 32'h0);
    chk({tag, " err"}, 32'({e1, e2, e4}), 32'h0);
  endtask

  // The request presented here is sampled on the next rising edge, returned as e.
  task automatic setreq(input logic en, input logic rd, input logic [7:0] a,
                        input logic [7:0] wd, output int e);
    enable = en;
    read   = rd;
    addr   = a;
    wdata  = wd;
    e      = cyc + 1;
  endtask

  task automatic req(input logic en, input logic rd, input logic [7:0] a,
                     input logic [7:0] wd, output int e);
    @(negedge clk);
    setreq(en, rd, a, wd, e);
  endtask

  // Idle cycles drive junk on the qualified inputs.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      enable = 1'b0;
      read   = 1'($urandom_range(0, 1));
      addr   = 8'($urandom);
      wdata  = 8'($urandom);
    end
  endtask

  int e, ew, er7, er0, e5, eoob, eoobw, er7b, erst, rel, epost, npulse, L;

  initial begin
    rst_n = 1'b1; enable = 1'b0; read = 1'b0; addr = '0; wdata = '0;
    #1 rst_n = 1'b0;
    #1 chk_now("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    setreq(1'b1, 1'b0, 8'd7, 8'hA5, ew);

    // Single write/read of address 7.
    req(1'b1, 1'b1, 8'd7, 8'h00, er7);
    idle(6);
    for (int k = 0; k < 3; k++) begin
      L = lat_of(k);
      chk($sformatf("rd7 valid L%0d", L), 32'(hv[k][er7+L-1]), 32'h1);
      chk($sformatf("rd7 data L%0d", L), 32'(hd[k][er7+L-1]), 32'hA5);
      chk($sformatf("rd7 early L%0d", L), 32'(hv[k][er7+L-2]), 32'h0);
      chk($sformatf("rd7 pulse L%0d", L), 32'(hv[k][er7+L]), 32'h0);
      chk($sformatf("rd7 hold L%0d", L), 32'(hd[k][er7+L]), 32'hA5);
    end

    // Four writes then four back-to-back reads.
    for (int j = 0; j < 4; j++) req(1'b1, 1'b0, 8'(j), 8'(8'h10 + j), e);
    for (int j = 0; j < 4; j++) begin
      req(1'b1, 1'b1, 8'(j), 8'h00, e);
      if (j == 0) er0 = e;
    end
    idle(8);
    for (int k = 0; k < 3; k++) begin
      L = lat_of(k);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("b2b valid L%0d #%0d", L, j), 32'(hv[k][er0+j+L-1]), 32'h1);
        chk($sformatf("b2b data L%0d #%0d", L, j), 32'(hd[k][er0+j+L-1]), 32'(8'h10 + j));
      end
      chk($sformatf("b2b before L%0d", L), 32'(hv[k][er0+L-2]), 32'h0);
      chk($sformatf("b2b after L%0d", L), 32'(hv[k][er0+L+3]), 32'h0);
    end

    // Read immediately after a write to the same address.
    req(1'b1, 1'b0, 8'd5, 8'h3C, e);
    req(1'b1, 1'b1, 8'd5, 8'h00, e5);
    idle(6);
    for (int k = 0; k < 3; k++) begin
      L = lat_of(k);
      chk($sformatf("raw valid L%0d", L), 32'(hv[k][e5+L-1]), 32'h1);
      chk($sformatf("raw data L%0d", L), 32'(hd[k][e5+L-1]), 32'h3C);
    end

    // Out-of-range read and write, disabled junk, then address 7 must be intact.
    req(1'b1, 1'b1, 8'd210, 8'h00, eoob);
    idle(6);
    req(1'b1, 1'b0, 8'd210, 8'h55, eoobw);
    req(1'b0, 1'b0, 8'd7, 8'hEE, e);
    req(1'b1, 1'b1, 8'd7, 8'h00, er7b);
    idle(6);
    for (int k = 0; k < 3; k++) begin
      L = lat_of(k);
      chk($sformatf("oor rd valid L%0d", L), 32'(hv[k][eoob+L-1]), 32'h1);
      chk($sformatf("oor rd err L%0d", L), 32'(he[k][eoob+L-1]), 32'h1);
      chk($sformatf("oor rd data L%0d", L), 32'(hd[k][eoob+L-1]), 32'hFF);
      chk($sformatf("oor rd err pulse L%0d", L), 32'(he[k][eoob+L]), 32'h0);
      chk($sformatf("oor wr err L%0d", L), 32'(he[k][eoobw]), 32'h1);
      chk($sformatf("oor wr valid L%0d", L), 32'(hv[k][eoobw]), 32'h0);
      chk($sformatf("oor wr err pulse L%0d", L), 32'(he[k][eoobw+1]), 32'h0);
      chk($sformatf("mem intact L%0d", L), 32'(hd[k][er7b+L-1]), 32'hA5);
      chk($sformatf("mem intact valid L%0d", L), 32'(hv[k][er7b+L-1]), 32'h1);
    end

    // Reset with a read in flight: no stray response, memory cleared.
    req(1'b1, 1'b1, 8'd7, 8'h00, erst);
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b0;
    #1 chk_now("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rel   = cyc;
    idle(8);
    for (int k = 0; k < 3; k++) begin
      npulse = 0;
      for (int i = erst + 1; i <= rel + 6; i++) npulse += int'(hv[k][i]);
      chk($sformatf("flushed L%0d", lat_of(k)), 32'(npulse), 32'h0);
    end
    req(1'b1, 1'b1, 8'd7, 8'h00, epost);
    idle(6);
    for (int k = 0; k < 3; k++) begin
      L = lat_of(k);
      chk($sformatf("post rst valid L%0d", L), 32'(hv[k][epost+L-1]), 32'h1);
      chk($sformatf("post rst data L%0d", L), 32'(hd[k][epost+L-1]), 32'h00);
      chk($sformatf("post rst err L%0d", L), 32'(he[k][epost+L-1]), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
